// File: rtl/pio_gen.sv
// pio_gen: Avalon-MM GPIO port with per-bit direction, synchronised inputs and edge-capture IRQ.
// Define PIO_GEN_BIT_ACCESS_EN to enable OUTSET (addr 4) / OUTCLR (addr 5) atomic bit access.

module pio_gen_lane #(
  parameter int EDGE_TYPE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic clr,
  output logic sync,
  output logic cap
);
  logic s1, s2, s3, edge_det;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    edge_det = 1'b0;
    case (EDGE_TYPE)
      1:       edge_det = ~s2 & s3;
      2:       edge_det = s2 ^ s3;
      default: edge_det = s2 & ~s3;
    endcase
  end

  // A fresh edge beats a same-cycle write-1-to-clear so no event is lost.
  always_ff @(posedge clk) begin
    if (reset) cap <= 1'b0;
    else       cap <= (cap & ~clr) | edge_det;
  end

  assign sync = s2;
endmodule

module pio_gen #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int               EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_DIR    = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_EDGE   = 3'd3;
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;

  logic             wr, rd;
  logic [WIDTH-1:0] wdata, out_q, dir_q, mask_q, sync_in, cap, cap_clr;
  logic [31:0]      rd_val;
  logic             wdata_unused;

  assign wr    = chipselect & ~write_n;
  assign rd    = chipselect & ~read_n;
  assign wdata = writedata[WIDTH-1:0];
  // Bits above WIDTH are intentionally dropped.
  assign wdata_unused = ^writedata;

  assign cap_clr = (wr && address == A_EDGE) ? wdata : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pio_gen_lane #(.EDGE_TYPE(EDGE_TYPE)) u_lane (
      .clk   (clk),
      .reset (reset),
      .pin   (in_port[i]),
      .clr   (cap_clr[i]),
      .sync  (sync_in[i]),
      .cap   (cap[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= RESET_VALUE;
      dir_q  <= DIR_RESET;
      mask_q <= '0;
    end else if (wr) begin
      case (address)
        A_DATA: out_q  <= wdata;
        A_DIR:  dir_q  <= wdata;
        A_MASK: mask_q <= wdata;
`ifdef PIO_GEN_BIT_ACCESS_EN
        A_OUTSET: out_q <= out_q | wdata;
        A_OUTCLR: out_q <= out_q & ~wdata;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(cap & mask_q);
  end

  always_comb begin
    rd_val = '0;
    case (address)
      A_DATA: rd_val[WIDTH-1:0] = (dir_q & out_q) | (~dir_q & sync_in);
      A_DIR:  rd_val[WIDTH-1:0] = dir_q;
      A_MASK: rd_val[WIDTH-1:0] = mask_q;
      A_EDGE: rd_val[WIDTH-1:0] = cap;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)   readdata <= '0;
    else if (rd) readdata <= rd_val;
  end

  assign out_port = out_q;
  assign oe       = dir_q;
endmodule

// File: doc/pio_gen.md
Name: pio_gen

Overview:
- Parametrised Avalon-MM general-purpose I/O port, the successor to the single-bit output-only PIO slaves in the system interconnect.
- Provides per-bit direction control, a synchronised input path and edge-capture with a maskable interrupt.
- Data width and reset values are configurable.
- Sits on the processor's Avalon bus and drives or samples board-level control pins (resets, camera enables, status lines).

Parameters:
- WIDTH, 8, number of I/O bits (1..32).
- RESET_VALUE, 0, out_port value after reset (WIDTH bits).
- DIR_RESET, 0, direction register value after reset (bit=1 means output).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe
- writedata  in  32  write data
- readdata  out  32  read data, registered
- in_port  in  WIDTH  external pin inputs (asynchronous)
- out_port  out  WIDTH  output data register
- oe  out  WIDTH  per-bit output enable (equals direction register)
- irq  out  1  level interrupt, active-high

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high; all state updates on posedge clk.
- Reset values: out_port=RESET_VALUE, dir=DIR_RESET, mask=0, capture=0, irq=0, readdata=0, sync flops=0.
- Write strobe: wr = chipselect & ~write_n.
- Read strobe: rd = chipselect & ~read_n.
- Register map (word addresses):
  - 0 DATA: write updates out_port[WIDTH-1:0]. Read returns per bit dir?out_port:sync_in.
  - 1 DIR: read/write.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: write-1-to-clear; read returns capture.
  - 4 OUTSET: write ORs writedata into out_port; reads 0.
  - 5 OUTCLR: write clears out_port bits where writedata=1; reads 0.
  - 6, 7: writes ignored, reads 0.
- Write width: writedata bits above WIDTH are ignored. Readdata bits above WIDTH are 0.
- Read latency: fixed 1 cycle; readdata is registered from the address sampled at the rd cycle. readdata holds its last value when rd=0.
- Input path: in_port feeds a 2-flop synchroniser (s1, s2), plus a delayed copy s3.
- Edge detection, per bit:
  - rising = s2 & ~s3
  - falling = ~s2 & s3
  - any = s2 ^ s3
- Latency: a pin change settled before clk edge k sets capture at edge k+2 and raises irq at edge k+3.
- Capture is independent of dir; output-configured bits still capture pin activity.
- irq is registered: irq <= |(capture & mask) each cycle.
- Simultaneous events:
  - Edge detected in the same cycle as a W1C of the same bit: set wins (bit stays 1).
  - Mask write and capture set in the same cycle: irq reflects both on the following edge.
- Reset mid-operation: all registers return to reset values on the next edge. A pending read returns 0. The synchroniser history is cleared, so no false edge is produced from in_port held at 0. A pin held at 1 through reset yields one rising edge two cycles after reset deasserts; this is intended.

Optional Feature:
- Macro: PIO_GEN_BIT_ACCESS_EN.
- Defined: OUTSET (addr 4) and OUTCLR (addr 5) are implemented as described.
- Undefined: addresses 4 and 5 behave like 6 and 7 (writes ignored, reads 0). out_port changes only via DATA writes.

Test Plan:
- Reset then read all 8 addresses with WIDTH=8, RESET_VALUE=8'hA5, DIR_RESET=8'hFF -> DATA=0xA5, DIR=0xFF, addrs 2..7 read 0 one cycle after rd; out_port=0xA5; oe=0xFF; irq=0.
- Write DIR=0x0F, DATA=0x3C; drive in_port=0xF0 for 3+ cycles -> out_port=0x3C, oe=0x0F, DATA read=0xFC.
- EDGE_TYPE=0, mask=0x01, in_port[0] 0->1 at edge k -> capture=0x01 at k+2, irq=1 at k+3. Write EDGE_CAP=0x01 -> irq=0 two edges later. Same-cycle edge plus clear -> capture stays 0x01.
- EDGE_TYPE=2 with in_port[3] pulsed high for 4 cycles -> capture bit 3 set on each edge. Mask=0 -> irq remains 0. Then mask=0x08 -> irq=1 the next cycle.
- Macro defined: DATA=0x00, OUTSET=0x81, OUTCLR=0x01 -> out_port=0x80. Macro undefined: same sequence -> out_port=0x00 and addr 4 reads 0.
- Assert reset mid-sequence after DATA=0x55, capture=0x02 -> next edge out_port=RESET_VALUE, capture=0, irq=0, readdata=0; writedata[31:8] ignored throughout.
